insfetch: RTL and testbench

INSFETCH -- requirements
Module: insfetch

---
 rtl/insfetch.sv | 181 ++++++++++++++++++
 tb/tb_insfetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/insfetch.sv
// Two-wide instruction fetch unit: issues aligned 8-byte fetches and
// buffers returned instructions in a circular queue for a dual decoder.
module insfetch #(
    parameter int PC    = 16,
    parameter int INS   = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    output logic [PC-1:0]    imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [2*INS-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [PC-1:0]    redirect_pc,
    output logic [INS-1:0]   instruction1,
    output logic [PC-1:0]    PC_in1,
    output logic             ins1_valid,
    output logic [INS-1:0]   instruction2,
    output logic [PC-1:0]    PC_in2,
    output logic             ins2_valid,
    input  logic             dec_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

    logic [PC-1:0]  fpc_q, fpc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [1:0]     outs_q, outs_d;
    logic [2:0]     drop_q, drop_d;
    logic [1:0]     skip_q, skip_d;
    logic           skip_wr_q, skip_wr_d;
    logic           skip_rd_q, skip_rd_d;
    logic [INS-1:0] ins_mem_q [DEPTH];
    logic [INS-1:0] ins_mem_d [DEPTH];
    logic [PC-1:0]  pc_mem_q  [DEPTH];
    logic [PC-1:0]  pc_mem_d  [DEPTH];

    logic [PC-1:0]  req_addr;
    logic [PC-1:0]  rsp_base;
    logic [CW+1:0]  credit_sum;
    logic           accept;
    logic           rsp_live;
    logic           rsp_take;
    logic           rsp_drop;
    logic           rsp_in_redir;
    logic           skip_cur;
    logic [1:0]     enq_n;
    logic [1:0]     deq_n;
    logic [AW-1:0]  head_p1;
    logic [AW-1:0]  tail_p1;
    logic           unused_ok;

    assign req_addr   = {fpc_q[PC-1:3], 3'b000};
    assign credit_sum = (CW+2)'(count_q) + (CW+2)'({outs_q, 1'b0}) + (CW+2)'(2);

    assign imem_req_valid = rst_n & ~redirect_valid & (outs_q != 2'd2)
                          & (credit_sum <= DEPTH_W);
    assign imem_req_addr  = req_addr;
    assign accept         = imem_req_valid & imem_req_ready;

    // Oldest in-flight fetch address: fpc has advanced 8 bytes per accept.
    assign rsp_base     = req_addr - PC'({outs_q, 3'b000});
    assign rsp_live     = imem_rsp_valid & ~redirect_valid & rst_n;
    assign rsp_drop     = rsp_live & (drop_q != 3'd0);
    assign rsp_take     = rsp_live & (drop_q == 3'd0) & (outs_q != 2'd0);
    assign rsp_in_redir = imem_rsp_valid & ((drop_q != 3'd0) | (outs_q != 2'd0));
    assign skip_cur     = skip_q[skip_rd_q];

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    assign ins1_valid   = (count_q != '0);
    assign ins2_valid   = (count_q >= CW'(2));
    assign instruction1 = ins1_valid ? ins_mem_q[head_q]  : '0;
    assign PC_in1       = ins1_valid ? pc_mem_q[head_q]   : '0;
    assign instruction2 = ins2_valid ? ins_mem_q[head_p1] : '0;
    assign PC_in2       = ins2_valid ? pc_mem_q[head_p1]  : '0;

    assign unused_ok = ^{redirect_pc[1:0], fpc_q[1:0]};

    always_comb begin
        enq_n = 2'd0;
        if (rsp_take) begin
            enq_n = skip_cur ? 2'd1 : 2'd2;
        end
        deq_n = 2'd0;
        if (dec_ready) begin
            deq_n = {1'b0, ins1_valid} + {1'b0, ins2_valid};
        end
    end

    always_comb begin
        fpc_d     = fpc_q;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        outs_d    = outs_q;
        drop_d    = drop_q;
        skip_d    = skip_q;
        skip_wr_d = skip_wr_q;
        skip_rd_d = skip_rd_q;
        if (redirect_valid) begin
            fpc_d     = {redirect_pc[PC-1:2], 2'b00};
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            outs_d    = '0;
            skip_wr_d = 1'b0;
            skip_rd_d = 1'b0;
            // Everything still in flight must be swallowed on return.
            drop_d    = drop_q + {1'b0, outs_q} - {2'b00, rsp_in_redir};
        end else begin
            if (accept) begin
                fpc_d             = req_addr + PC'(8);
                skip_d[skip_wr_q] = fpc_q[2];
                skip_wr_d         = ~skip_wr_q;
            end
            if (rsp_take) begin
                skip_rd_d = ~skip_rd_q;
            end
            outs_d  = outs_q + {1'b0, accept} - {1'b0, rsp_take};
            drop_d  = drop_q - {2'b00, rsp_drop};
            count_d = count_q + CW'(enq_n) - CW'(deq_n);
            head_d  = head_q + AW'(deq_n);
            tail_d  = tail_q + AW'(enq_n);
        end
    end

    always_comb begin
        ins_mem_d = ins_mem_q;
        pc_mem_d  = pc_mem_q;
        if (rsp_take) begin
            if (skip_cur) begin
                ins_mem_d[tail_q] = imem_rsp_data[2*INS-1:INS];
                pc_mem_d[tail_q]  = rsp_base + PC'(4);
            end else begin
                ins_mem_d[tail_q]  = imem_rsp_data[INS-1:0];
                pc_mem_d[tail_q]   = rsp_base;
                ins_mem_d[tail_p1] = imem_rsp_data[2*INS-1:INS];
                pc_mem_d[tail_p1]  = rsp_base + PC'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q     <= '0;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            outs_q    <= '0;
            drop_q    <= '0;
            skip_q    <= '0;
            skip_wr_q <= 1'b0;
            skip_rd_q <= 1'b0;
        end else begin
            fpc_q     <= fpc_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            outs_q    <= outs_d;
            drop_q    <= drop_d;
            skip_q    <= skip_d;
            skip_wr_q <= skip_wr_d;
            skip_rd_q <= skip_rd_d;
        end
    end

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        ins_mem_q <= ins_mem_d;
        pc_mem_q  <= pc_mem_d;
    end

endmodule

// File: tb/tb_insfetch.sv
// Scoreboard bench for insfetch: a latency-configurable memory model
// answers fetches, a decoder process pops and checks queued instructions.
module tb_insfetch;

    localparam int PCW   = 16;
    localparam int INSW  = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req_valid;
    logic [PCW-1:0]    imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [2*INSW-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [PCW-1:0]    redirect_pc;
    logic [INSW-1:0]   instruction1;
    logic [PCW-1:0]    PC_in1;
    logic              ins1_valid;
    logic [INSW-1:0]   instruction2;
    logic [PCW-1:0]    PC_in2;
    logic              ins2_valid;
    logic              dec_ready;

    insfetch #(.PC(PCW), .INS(INSW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instruction1  (instruction1),
        .PC_in1        (PC_in1),
        .ins1_valid    (ins1_valid),
        .instruction2  (instruction2),
        .PC_in2        (PC_in2),
        .ins2_valid    (ins2_valid),
        .dec_ready     (dec_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [31:0] wf(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: in-order responses, 'lat' cycles after acceptance.
    typedef struct {
        logic [15:0] a;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc    = 0;
    int          lat    = 1;
    int          n_acc  = 0;
    logic        acc_s  = 1'b0;
    logic        rst_s  = 1'b0;
    logic [15:0] addr_s = '0;
    logic [15:0] exp_next = '0;

    always @(negedge clk) begin
        acc_s  = imem_req_valid && imem_req_ready;
        addr_s = imem_req_addr;
        rst_s  = rst_n;
        if (acc_s) begin
            n_acc++;
            chk("req_addr", 64'(addr_s), 64'(exp_next));
            exp_next = exp_next + 16'd8;
        end
    end

    always @(posedge clk) begin
        mreq_t m;
        cyc++;
        #1;
        if (!rst_s) mq.delete();
        if (acc_s) mq.push_back('{addr_s, cyc + lat});
        imem_rsp_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {wf(m.a + 16'd4), wf(m.a)};
        end
    end

    // Decoder + monitor: consumes only what the scoreboard expects.
    logic [15:0] sb[$];
    logic        dec_en = 1'b0;

    always @(negedge clk) begin
        int          n;
        logic [15:0] e;
        n = int'(ins1_valid) + int'(ins2_valid);
        if (dec_en && n > 0 && sb.size() >= n) begin
            dec_ready = 1'b1;
            e = sb.pop_front();
            chk("dec_pc1", 64'(PC_in1), 64'(e));
            chk("dec_ins1", 64'(instruction1), 64'(wf(e)));
            if (ins2_valid) begin
                e = sb.pop_front();
                chk("dec_pc2", 64'(PC_in2), 64'(e));
                chk("dec_ins2", 64'(instruction2), 64'(wf(e)));
            end
        end else begin
            dec_ready = 1'b0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_sb(input int maxc, input string nm);
        int k = 0;
        while (sb.size() > 0 && k < maxc) begin
            step();
            k++;
        end
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int found;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        step(3);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_ins1_valid", 64'(ins1_valid), 64'd0);
        chk("rst_ins2_valid", 64'(ins2_valid), 64'd0);
        chk("rst_pc1", 64'(PC_in1), 64'd0);
        chk("rst_ins1", 64'(instruction1), 64'd0);
        chk("rst_pc2", 64'(PC_in2), 64'd0);
        chk("rst_ins2", 64'(instruction2), 64'd0);

        // Decoder stalled: queue fills with exactly four fetches
        exp_next = 16'h0000;
        n_acc    = 0;
        rst_n    = 1'b1;
        step(15);
        chk("stall_accepts", 64'(n_acc), 64'd4);
        chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
        chk("stall_ins1_valid", 64'(ins1_valid), 64'd1);
        chk("stall_ins2_valid", 64'(ins2_valid), 64'd1);
        chk("stall_pc1", 64'(PC_in1), 64'h0000);
        chk("stall_pc2", 64'(PC_in2), 64'h0004);
        chk("stall_ins2", 64'(instruction2), 64'(wf(16'h0004)));

        // Resume decoding: sequential pairs in order
        for (int i = 0; i < 12; i++) sb.push_back(16'(i * 4));
        dec_en = 1'b1;
        wait_sb(200, "drain_seq");
        dec_en = 1'b0;
        chk("resume_fetch", 64'(n_acc > 4), 64'd1);

        // Redirect with two fetches outstanding
        lat   = 3;
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        exp_next = 16'h0000;
        n_acc    = 0;
        step(2);
        chk("two_outstanding", 64'(n_acc), 64'd2);
        chk("out2_req_valid", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0124;
        exp_next       = 16'h0120;
        step();
        redirect_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ins1_valid) begin
                found = 1;
                break;
            end
        end
        chk("redir_found", 64'(found), 64'd1);
        chk("redir_pc1", 64'(PC_in1), 64'h0124);
        chk("redir_ins1", 64'(instruction1), 64'(wf(16'h0124)));
        chk("redir_ins2_valid", 64'(ins2_valid), 64'd0);
        chk("redir_pc2_zero", 64'(PC_in2), 64'd0);
        chk("redir_ins2_zero", 64'(instruction2), 64'd0);
        for (int i = 0; i < 7; i++) sb.push_back(16'(16'h0124 + i * 4));
        dec_en = 1'b1;
        step();
        // One dequeued while a pair arrived: the new pair is presented
        chk("sim_ins1_valid", 64'(ins1_valid), 64'd1);
        chk("sim_ins2_valid", 64'(ins2_valid), 64'd1);
        chk("sim_pc1", 64'(PC_in1), 64'h0128);
        chk("sim_pc2", 64'(PC_in2), 64'h012C);
        wait_sb(300, "drain_redir");
        dec_en = 1'b0;

        // Address wrap at the top of the space, unaligned redirect pc
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFF2;
        exp_next       = 16'hFFF0;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) sb.push_back(16'(16'hFFF0 + i * 4));
        dec_en = 1'b1;
        wait_sb(300, "drain_wrap");
        dec_en = 1'b0;

        // Reset mid-operation with queued and in-flight fetches
        lat = 3;
        step(6);
        chk("pre_reset_ins2_valid", 64'(ins2_valid), 64'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("mid_rst_ins1_valid", 64'(ins1_valid), 64'd0);
        chk("mid_rst_ins2_valid", 64'(ins2_valid), 64'd0);
        chk("mid_rst_pc1", 64'(PC_in1), 64'd0);
        chk("mid_rst_ins1", 64'(instruction1), 64'd0);
        lat      = 1;
        exp_next = 16'h0000;
        rst_n    = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(16'(i * 4));
        dec_en = 1'b1;
        wait_sb(200, "drain_post_rst");
        dec_en = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
